serial_operand_feeder: RTL and testbench

- Upstream stage of serial_adder_with_vld.
- Accepts a pair of WIDTH-bit operands through a valid/ready handshake.
- Shifts the pair out LSB-first, one bit pair per cycle, on the adder's a/b/vld/last inputs.
- Supports back-to-back operands with no bubble, and supports a downstream stall.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/serial_shift_reg.sv | 35 +++
 rtl/serial_operand_feeder.sv | 137 +++++++++++++
 tb/tb_serial_operand_feeder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial operand path (feeder and
// result collector).
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_t;

  // Bit-index counter width for a WIDTH-bit serial word.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Width of a length field that must be able to hold the value WIDTH.
  function automatic int len_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Loadable right-shift register presenting its LSB; load wins over shift.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = {1'b0, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bit_o = data_q[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Serialises WIDTH-bit operand pairs LSB-first for a serial adder.
// Optional macro SERIAL_OPERAND_FEEDER_VAR_LEN_EN adds a per-pair length (in_len).
//
// Handshake: a pair transfers on a rising edge where in_vld & in_rdy; in_rdy
// depends only on rst, state, stall and the bit counter, never on in_vld.
module serial_operand_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
`ifdef SERIAL_OPERAND_FEEDER_VAR_LEN_EN
  input  logic [$clog2(WIDTH+1)-1:0] in_len,
`endif
  input  logic                       stall,
  output logic                       out_vld,
  output logic                       out_a,
  output logic                       out_b,
  output logic                       out_last,
  output logic                       dbg_state_o
);

  localparam int CW = cnt_w(WIDTH);

  feeder_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load;
  logic            shift;
  logic            last_bit;

`ifdef SERIAL_OPERAND_FEEDER_VAR_LEN_EN
  localparam int LW = len_w(WIDTH);
  logic [LW-1:0] len_q, len_d;

  // Out-of-range lengths (0 or above WIDTH) fall back to the full width.
  always_comb begin
    len_d = len_q;
    if (load) begin
      len_d = ((in_len == '0) || (in_len > LW'(WIDTH))) ? LW'(WIDTH) : in_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= LW'(WIDTH);
    end else begin
      len_q <= len_d;
    end
  end

  assign last_bit = (cnt_q == CW'(len_q - 1'b1));
`else
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift    = 1'b0;
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    out_last = 1'b0;
    case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_vld = ~stall;
        if (!stall) begin
          shift = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (last_bit) begin
            in_rdy   = 1'b1;
            out_last = 1'b1;
            // A waiting pair is reloaded on the same edge: no bubble.
            if (in_vld) begin
              load  = 1'b1;
              cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The adder is reset alongside us, so nothing is offered during reset.
    if (rst) begin
      in_rdy   = 1'b0;
      out_vld  = 1'b0;
      out_last = 1'b0;
      load     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  serial_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .shift_i(shift),
    .data_i (in_a),
    .bit_o  (out_a)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .shift_i(shift),
    .data_i (in_b),
    .bit_o  (out_b)
  );

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Scoreboard bench for serial_operand_feeder (WIDTH=8) with a serial adder model.
module tb_serial_operand_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         stall = 1'b0;
  logic         out_vld, out_a, out_b, out_last, dbg_state;
`ifdef SERIAL_OPERAND_FEEDER_VAR_LEN_EN
  logic [3:0]   in_len = 4'd0;
`endif

  int tests = 0;
  int fails = 0;

  // {last, a, b} per expected bit pair; expected 8-bit sums per operation
  logic [2:0]   exp_q[$];
  logic [W-1:0] sum_q[$];

  int cyc = 0;
  int run_len = 0;
  int max_run = 0;
  int first_cyc = 0;
  int done_cyc = 0;

  always #5 clk = ~clk;

  serial_operand_feeder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_a       (in_a),
    .in_b       (in_b),
`ifdef SERIAL_OPERAND_FEEDER_VAR_LEN_EN
    .in_len     (in_len),
`endif
    .stall      (stall),
    .out_vld    (out_vld),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_last   (out_last),
    .dbg_state_o(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int len, input logic [W-1:0] sum);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1), a[i], b[i]});
    end
    sum_q.push_back(sum);
  endtask

  // Hold the pair valid until it transfers (bounded), then record expectations.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input int len, input logic [W-1:0] sum);
    int n;
    in_a   = a;
    in_b   = b;
    in_vld = 1'b1;
`ifdef SERIAL_OPERAND_FEEDER_VAR_LEN_EN
    in_len = 4'(len);
`endif
    n = 0;
    @(negedge clk);
    while (!in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_rdy stayed %0b, required 1", in_rdy);
    end
    @(posedge clk);
    push_exp(a, b, len, sum);
    #1 in_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d bits outstanding, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected bits on every out_vld and rebuilds the adder sum.
  logic         carry = 1'b0;
  logic [W-1:0] acc = '0;
  int           idx = 0;

  always @(negedge clk) begin
    logic [2:0] e;
    logic       s;
    cyc++;
    if (out_last && !out_vld) begin
      tests++;
      fails++;
      $display("FAIL last_without_vld: out_last=1 out_vld=0, required out_last=0");
    end
    if (rst) begin
      exp_q.delete();
      sum_q.delete();
      carry   = 1'b0;
      acc     = '0;
      idx     = 0;
      run_len = 0;
    end else if (out_vld) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_bit: got {last,a,b}=%b with empty queue", {out_last, out_a, out_b});
      end else begin
        e = exp_q.pop_front();
        if (idx == 0) first_cyc = cyc;
        chk("bit_pair", {out_last, out_a, out_b}, e);
        s        = out_a ^ out_b ^ carry;
        carry    = (out_a & out_b) | (carry & (out_a ^ out_b));
        acc[idx] = s;
        idx++;
        if (e[2]) begin
          done_cyc = cyc;
          if (sum_q.size() != 0) chk("adder_sum", acc, sum_q.pop_front());
          carry = 1'b0;
          acc   = '0;
          idx   = 0;
        end
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rdy_in_reset", in_rdy, 1'b0);
    chk("vld_in_reset", out_vld, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_reset", in_rdy, 1'b1);
    chk("out_after_reset", {out_vld, out_last, out_a, out_b}, 4'b0000);
    chk("state_after_reset", dbg_state, 1'b0);

    // Single op: A5 + 3C = E1, 8 cycles, last on the 8th
    @(posedge clk);
    #1;
    send(8'hA5, 8'h3C, 8, 8'hE1);
    wait_idle();
    chk("single_span", done_cyc - first_cyc + 1, 8);

    // Back-to-back: FF/01 waits during the first op, 16 consecutive vld cycles
    max_run = 0;
    send(8'hA5, 8'h3C, 8, 8'hE1);
    send(8'hFF, 8'h01, 8, 8'h00);
    wait_idle();
    chk("b2b_run", max_run, 16);

    // Stall for 3 cycles on bit 4
    send(8'h5A, 8'hC3, 8, 8'h1D);
    repeat (4) @(posedge clk);
    #1 stall = 1'b1;
    @(negedge clk);
    chk("stall_vld_low", out_vld, 1'b0);
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_idle();
    chk("stall_span", done_cyc - first_cyc + 1, 11);

    // Stall on the last bit with a pair pending
    send(8'h0F, 8'h0F, 8, 8'h1E);
    repeat (7) @(posedge clk);
    #1 stall = 1'b1;
    in_a   = 8'h81;
    in_b   = 8'h7E;
    in_vld = 1'b1;
    @(negedge clk);
    chk("stall_last_rdy", in_rdy, 1'b0);
    chk("stall_last_nolast", out_last, 1'b0);
    @(posedge clk);
    #1 stall = 1'b0;
    @(negedge clk);
    chk("stall_last_rdy_after", in_rdy, 1'b1);
    @(posedge clk);
    push_exp(8'h81, 8'h7E, 8, 8'hFF);
    #1 in_vld = 1'b0;
    wait_idle();

    // Reset mid-op on bit 5, then 01 + 01 = 02
    send(8'hA5, 8'h3C, 8, 8'hE1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_vld", out_vld, 1'b0);
    chk("rst_mid_rdy", in_rdy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_vld_after", out_vld, 1'b0);
    chk("rst_mid_rdy_after", in_rdy, 1'b1);
    @(posedge clk);
    #1;
    send(8'h01, 8'h01, 8, 8'h02);
    wait_idle();

`ifdef SERIAL_OPERAND_FEEDER_VAR_LEN_EN
    // One-bit operation: vld, last and in_rdy together on the only bit
    send(8'h01, 8'h01, 1, 8'h00);
    @(negedge clk);
    chk("len1_vld_last_rdy", {out_vld, out_last, in_rdy}, 3'b111);
    wait_idle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
